// File: rtl/seg_capture_decoder.sv
// Samples two active-low 7-segment patterns, filters them for stability and
// presents each newly stable digit pair, decoded back to BCD, over valid/ready.
module seg_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg1_in,
    input  logic [6:0] seg2_in,
    output logic [3:0] bcd1_out,
    output logic [3:0] bcd2_out,
    output logic [1:0] err_out,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYCLES);
    localparam logic [13:0] BLANK_PAIR = {7'h7F, 7'h7F};

    typedef enum logic {
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [13:0] prev_q, prev_d;
    logic [13:0] acc_q, acc_d;
    logic [CW-1:0] run_q, run_d;
    logic [3:0]  bcd1_q, bcd1_d;
    logic [3:0]  bcd2_q, bcd2_d;
    logic [1:0]  err_q, err_d;
    logic [13:0] pair;
    logic [4:0]  dec1, dec2;

    // Returns {illegal, bcd}; blank is a legal "no digit" shown as F.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b1111111: decode = 5'h0F;
            default:    decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
        pair    = {seg1_in, seg2_in};
        prev_d  = pair;
        state_d = state_q;
        acc_d   = acc_q;
        bcd1_d  = bcd1_q;
        bcd2_d  = bcd2_q;
        err_d   = err_q;
        dec1    = decode(seg1_in);
        dec2    = decode(seg2_in);

        if (pair == prev_q) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + CW'(1);
        end else begin
            run_d = CW'(1);
        end

        case (state_q)
            S_WAIT: begin
                if (run_d == RUN_MAX && pair != acc_q) begin
                    bcd1_d  = dec1[3:0];
                    bcd2_d  = dec2[3:0];
                    err_d   = {dec2[4], dec1[4]};
                    acc_d   = pair;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            prev_q  <= BLANK_PAIR;
            acc_q   <= BLANK_PAIR;
            run_q   <= '0;
            bcd1_q  <= 4'hF;
            bcd2_q  <= 4'hF;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
            bcd1_q  <= bcd1_d;
            bcd2_q  <= bcd2_d;
            err_q   <= err_d;
        end
    end

    assign bcd1_out  = bcd1_q;
    assign bcd2_out  = bcd2_q;
    assign err_out   = err_q;
    assign out_valid = (state_q == S_HOLD);

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Scoreboard bench for seg_capture_decoder: a pair-level reference model pushes
// expected presentations; a negedge monitor pops and checks what the DUT shows.
module tb_seg_capture_decoder;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg1_in, seg2_in;
    logic [3:0] bcd1_out, bcd2_out;
    logic [1:0] err_out;
    logic       out_valid;
    logic       out_ready;

    seg_capture_decoder #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg1_in   (seg1_in),
        .seg2_in   (seg2_in),
        .bcd1_out  (bcd1_out),
        .bcd2_out  (bcd2_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expected presentation packed as {err[1:0], bcd1, bcd2}.
    logic [9:0] exp_q[$];

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [6:0] bad [3]  = '{7'b0101010, 7'b1111110, 7'b0001111};

    function automatic logic [4:0] ref_dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (p == pat[i]) return {1'b0, 4'(i)};
        if (p == 7'h7F) return 5'h0F;
        return 5'h1E;
    endfunction

    // Reference model: how long the current pair has been on the inputs,
    // the last pair reported, and whether a report is still unaccepted.
    int          m_len;
    logic [13:0] m_prev, m_last;
    bit          m_busy;

    task automatic model_edge();
        logic [13:0] p;
        logic [4:0]  d1, d2;
        p = {seg1_in, seg2_in};
        if (!rst_n) begin
            m_len = 0; m_prev = 14'h3FFF; m_last = 14'h3FFF; m_busy = 0;
            return;
        end
        m_len  = (p == m_prev) ? ((m_len + 1 > S) ? S : m_len + 1) : 1;
        m_prev = p;
        if (m_busy) begin
            if (out_ready) m_busy = 0;
        end else if (m_len == S && p != m_last) begin
            d1 = ref_dec(seg1_in);
            d2 = ref_dec(seg2_in);
            exp_q.push_back({d2[4], d1[4], d1[3:0], d2[3:0]});
            m_last = p;
            m_busy = 1;
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic rdy,
                         input logic rn, input int n);
        for (int i = 0; i < n; i++) begin
            seg1_in = a; seg2_in = b; out_ready = rdy; rst_n = rn;
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    // Monitor
    logic       prev_rst   = 1'b1;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [9:0] held;
    logic [9:0] now_out;
    logic [9:0] exp_v;

    always @(negedge clk) begin
        now_out = {err_out, bcd1_out, bcd2_out};
        if (!prev_rst) begin
            compared++;
            if (out_valid !== 1'b0 || now_out !== 10'h0FF) begin
                mismatched++;
                $display("FAIL reset_state: valid=%b out=%h required valid=0 out=0ff", out_valid, now_out);
            end
        end else if (prev_valid && !prev_hs) begin
            compared++;
            if (out_valid !== 1'b1 || now_out !== held) begin
                mismatched++;
                $display("FAIL hold_stable: valid=%b out=%h required valid=1 out=%h", out_valid, now_out, held);
            end
        end else if (out_valid === 1'b1) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid: out=%h required no presentation", now_out);
            end else begin
                exp_v = exp_q.pop_front();
                if (now_out !== exp_v) begin
                    mismatched++;
                    $display("FAIL capture_data: out=%h required %h", now_out, exp_v);
                end
            end
            held = now_out;
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL missed_capture: valid=%b required presentation %h", out_valid, exp_q[0]);
            exp_q.delete();
        end
        prev_rst   = rst_n;
        prev_valid = out_valid;
        prev_hs    = out_valid & out_ready;
    end

    localparam logic [6:0] BLK = 7'h7F;

    initial begin
        int n;
        logic [6:0] a, b;
        m_len = 0; m_prev = 14'h3FFF; m_last = 14'h3FFF; m_busy = 0;
        seg1_in = BLK; seg2_in = BLK; out_ready = 1'b0; rst_n = 1'b0;
        #1;
        // 1: reset then idle blank
        drive(BLK, BLK, 1'b0, 1'b0, 2);
        drive(BLK, BLK, 1'b0, 1'b1, 20);
        // 2: 2/9 held, hold outputs, accept
        drive(pat[2], pat[9], 1'b0, 1'b1, 14);
        drive(pat[2], pat[9], 1'b1, 1'b1, 1);
        drive(pat[2], pat[9], 1'b0, 1'b1, 3);
        // 3: short 5/5 then 6/6
        drive(pat[5], pat[5], 1'b1, 1'b1, 3);
        drive(pat[6], pat[6], 1'b1, 1'b1, 6);
        // 4: illegal digit 1
        drive(bad[0], pat[0], 1'b1, 1'b1, 6);
        // 5: acc suppression, blip, blank report, re-report
        drive(pat[2], pat[9], 1'b1, 1'b1, 8);
        drive(pat[2], pat[9], 1'b1, 1'b1, 20);
        drive(BLK, BLK, 1'b1, 1'b1, 2);
        drive(pat[2], pat[9], 1'b1, 1'b1, 6);
        drive(BLK, BLK, 1'b1, 1'b1, 6);
        drive(pat[2], pat[9], 1'b1, 1'b1, 6);
        // 6: reset while holding
        drive(pat[3], pat[1], 1'b0, 1'b1, 6);
        drive(pat[3], pat[1], 1'b0, 1'b0, 1);
        drive(pat[3], pat[1], 1'b0, 1'b1, 6);
        drive(pat[3], pat[1], 1'b1, 1'b1, 2);
        // randomized segments from a small pool so repeats and suppression occur
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 5))
                0:       a = BLK;
                1:       a = bad[$urandom_range(0, 2)];
                default: a = pat[$urandom_range(0, 3)];
            endcase
            b = ($urandom_range(0, 3) == 0) ? bad[$urandom_range(0, 2)] : pat[$urandom_range(0, 2)];
            n = $urandom_range(1, 7);
            for (int c = 0; c < n; c++)
                drive(a, b, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) != 0), 1);
        end
        drive(BLK, BLK, 1'b1, 1'b1, 10);
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL final_queue: pending=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
